cr_kme_fifo_arb: RTL and testbench
==================================

// Module: cr_kme_fifo_arb
// PURPOSE
//  Packet-level round-robin arbiter that shares one KME DATA_SIZE-wide stall/valid FIFO between N_REQ producers.
//  Sits in front of the FIFO's write port.
//  Grants one requester at a time and holds the grant until that requester's EOP beat is written.
//  Issues a write only when the FIFO is not stalling, so the FIFO never overflows by construction.
//  Length watchdog and sticky error flags for the KME datapath.
// PARAMETERS
//  N_REQ      4    number of requesters (2..8)
//  DATA_SIZE  106  beat width, matches the FIFO data width
//  MAX_BEATS  16   max beats per packet before the watchdog forces a release (2..255)
// PORTS
//  clk            in   1                clock
//  rst            in   1                synchronous reset, active-high
//  req_valid      in   N_REQ            requester i has a beat available
//  req_data       in   N_REQ*DATA_SIZE  beat of requester i at [i*DATA_SIZE +: DATA_SIZE]
//  req_eop        in   N_REQ            beat of requester i is the last beat of its packet
//  req_ack        out  N_REQ            one-hot; beat of requester i consumed this cycle
//  fifo_in        out  DATA_SIZE        write data to the FIFO
//  fifo_in_valid  out  1                FIFO write enable
//  fifo_in_stall  in   1                FIFO has no free slot
//  fifo_overflow  in   1                FIFO overflow pulse
//  gnt_active     out  1                a packet grant is held
//  gnt_id         out  3                index of the granted requester (valid when gnt_active=1)
//  err_len        out  1                sticky: watchdog fired
//  err_ovf        out  1                sticky: fifo_overflow seen
//  err_clr        in   1                clears both sticky errors
// BEHAVIOUR
//  - Reset, synchronous, dominates all inputs:
//    - state=IDLE, rr_ptr=0, beat_cnt=0.
//    - gnt_active=0, gnt_id=0, err_len=0, err_ovf=0.
//    - req_ack=0, fifo_in_valid=0 combinationally from state.
//  - FSM states:
//    - IDLE: waits for any req_valid.
//      - Picks the first set req_valid at or after rr_ptr (circular scan).
//      - Registers gnt_id and goes to XFER. Arbitration costs 1 cycle; no beat is written in IDLE.
//    - XFER: beat fires when fire = req_valid[gnt_id] & !fifo_in_stall.
//      - On fire: fifo_in_valid=1, fifo_in=req_data[gnt_id], req_ack[gnt_id]=1, beat_cnt++.
//      - fifo_in_valid and req_ack are combinational from the registered grant.
//      - fifo_in is held at req_data[gnt_id] while in XFER and is 0 in IDLE.
//    - Packet end: a fire with req_eop[gnt_id]=1 goes to IDLE.
//      - rr_ptr=(gnt_id+1) mod N_REQ; beat_cnt=0.
//    - Watchdog: a fire with beat_cnt==MAX_BEATS-1 and req_eop=0 goes to IDLE.
//      - err_len=1; rr_ptr advances as at packet end.
//      - The remainder of the packet is arbitrated as a new packet.
//  - Best-case throughput is 1 beat/cycle inside a packet, with a 1-cycle bubble between packets.
//  - req_valid deasserting mid-packet: the grant is held and no beat is written. There is no timeout on idle gaps.
//  - fifo_in_stall=1: no write and no ack. Data need not be held by the arbiter; requesters hold until acked.
//  - Sticky errors:
//    - fifo_overflow sets err_ovf the cycle after.
//    - err_clr clears both errors; a set and a clear in the same cycle leave the error set.
//  - rr_ptr wrap: index N_REQ-1 wraps to 0.
//  - N_REQ=1 degenerates to pass-through with the IDLE bubble.
// CONFIGURATION
//  - Macro CR_KME_FIFO_ARB_PRIO0_EN.
//  - Defined: requester 0 has strict priority at every IDLE arbitration.
//    - Other requesters are scanned round-robin only when req_valid[0]=0.
//    - rr_ptr is not advanced by grants to requester 0.
//  - Undefined: pure round-robin as above.
//  - Neither setting changes the port list.
// TESTING
//  - Reset: hold rst with all req_valid=1 -> req_ack=0, fifo_in_valid=0, gnt_active=0 every cycle; first grant to req 0 on the cycle after rst drops.
//  - Round-robin: req 0..3 each send a 2-beat packet, all valid from t0 -> grants 0,1,2,3 in order; 8 writes; 1 idle cycle between packets; rr_ptr ends at 0.
//  - Stall: req 1 sends a 3-beat packet while fifo_in_stall=1 for 5 cycles mid-packet -> no fifo_in_valid during the stall; beats written in order; data matches.
//  - Watchdog: MAX_BEATS=4, req 2 sends 6 beats with no EOP -> 4 writes, then IDLE, err_len=1, then the remaining 2 beats under a new grant; err_clr -> err_len=0.
//  - Overflow: force fifo_overflow=1 for 1 cycle -> err_ovf=1 next cycle; err_clr and fifo_overflow together -> err_ovf stays 1.
//  - PRIO0_EN: req 0 and req 3 continuously valid with 1-beat packets -> with macro, req 0 is always granted; without it, grants alternate 0,3,0,3.

Source files
------------

// File: rtl/cr_kme_fifo_arb.sv
// Packet-level round-robin arbiter in front of the KME FIFO write port, with length watchdog and sticky errors.
// Optional macro CR_KME_FIFO_ARB_PRIO0_EN gives requester 0 strict priority at every arbitration.
module cr_kme_fifo_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_SIZE = 106,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_SIZE-1:0] req_data,
    input  logic [N_REQ-1:0]           req_eop,
    output logic [N_REQ-1:0]           req_ack,
    output logic [DATA_SIZE-1:0]       fifo_in,
    output logic                       fifo_in_valid,
    input  logic                       fifo_in_stall,
    input  logic                       fifo_overflow,
    output logic                       gnt_active,
    output logic [2:0]                 gnt_id,
    output logic                       err_len,
    output logic                       err_ovf,
    input  logic                       err_clr
);

    typedef enum logic {IDLE, XFER} state_e;

    state_e         state_q, state_d;
    logic [2:0]     rr_ptr_q, rr_ptr_d;
    logic [2:0]     gnt_id_q, gnt_id_d;
    logic [7:0]     beat_cnt_q, beat_cnt_d;
    logic           err_len_q, err_len_d;
    logic           err_ovf_q, err_ovf_d;

    logic                 cur_valid;
    logic                 cur_eop;
    logic [DATA_SIZE-1:0] cur_data;
    logic                 fire;
    logic                 wd_fire;
    logic [2:0]           next_ptr;
    logic [2:0]           pick;
    logic                 found;
    int unsigned          scan_idx;

    // Granted requester's lane, selected by the registered grant.
    always_comb begin
        cur_valid = 1'b0;
        cur_eop   = 1'b0;
        cur_data  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_id_q == 3'(i)) begin
                cur_valid = req_valid[i];
                cur_eop   = req_eop[i];
                cur_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign fire     = (state_q == XFER) && cur_valid && !fifo_in_stall;
    assign wd_fire  = fire && !cur_eop && (beat_cnt_q == 8'(MAX_BEATS - 1));
    assign next_ptr = (gnt_id_q == 3'(N_REQ - 1)) ? 3'd0 : gnt_id_q + 3'd1;

    // Circular scan starting at rr_ptr; with the priority macro, requester 0 pre-empts the scan.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = 0;
`ifdef CR_KME_FIFO_ARB_PRIO0_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end
`endif
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                pick  = 3'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        beat_cnt_d = beat_cnt_q;
        err_len_d  = err_len_q && !err_clr;
        err_ovf_d  = fifo_overflow || (err_ovf_q && !err_clr);
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_id_d   = pick;
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (fire) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (cur_eop || wd_fire) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
`ifdef CR_KME_FIFO_ARB_PRIO0_EN
                        if (gnt_id_q != 3'd0) rr_ptr_d = next_ptr;
`else
                        rr_ptr_d = next_ptr;
`endif
                    end
                    if (wd_fire) err_len_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_id_q   <= '0;
            beat_cnt_q <= '0;
            err_len_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            beat_cnt_q <= beat_cnt_d;
            err_len_q  <= err_len_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    always_comb begin
        req_ack = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ack[i] = fire && (gnt_id_q == 3'(i));
        end
    end

    assign fifo_in_valid = fire;
    assign fifo_in       = (state_q == XFER) ? cur_data : '0;
    assign gnt_active    = (state_q == XFER);
    assign gnt_id        = gnt_id_q;
    assign err_len       = err_len_q;
    assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// Self-checking bench for cr_kme_fifo_arb: requester queues feed the DUT, expected writes sit in a scoreboard.
// Build with +define+CR_KME_FIFO_ARB_PRIO0_EN to check the strict-priority variant.
module tb_cr_kme_fifo_arb;
    localparam int unsigned N  = 4;
    localparam int unsigned DS = 106;
    localparam int unsigned MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DS-1:0] req_data = '0;
    logic [N-1:0]    req_eop = '0;
    logic [N-1:0]    req_ack;
    logic [DS-1:0]   fifo_in;
    logic            fifo_in_valid;
    logic            fifo_in_stall = 1'b0;
    logic            fifo_overflow = 1'b0;
    logic            gnt_active;
    logic [2:0]      gnt_id;
    logic            err_len;
    logic            err_ovf;
    logic            err_clr = 1'b0;

    always #5 clk = ~clk;

    cr_kme_fifo_arb #(.N_REQ(N), .DATA_SIZE(DS), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_eop(req_eop),
        .req_ack(req_ack), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
        .fifo_in_stall(fifo_in_stall), .fifo_overflow(fifo_overflow), .gnt_active(gnt_active),
        .gnt_id(gnt_id), .err_len(err_len), .err_ovf(err_ovf), .err_clr(err_clr)
    );

    typedef struct { logic [DS-1:0] data; logic eop; } beat_t;
    typedef struct { logic [2:0] id; logic [DS-1:0] data; } exp_t;
    typedef struct { logic ovf; logic clr; logic exp_ovf; logic exp_len; } vec_t;

    beat_t rq[N][$];
    exp_t  sb[$];
    vec_t  vecs[8];

    int    n_tests = 0;
    int    n_fail = 0;
    int    writes = 0;
    int    seq = 0;
    logic  last_gnt_active;
    logic  [2:0] last_gnt_id;

    task automatic check(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DS +: DS]  = rq[i][0].data;
                req_eop[i]            = rq[i][0].eop;
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DS +: DS]  = '0;
                req_eop[i]            = 1'b0;
            end
        end
    endtask

    task automatic load_pkt(input int id, input int nbeats, input logic eop_last);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < nbeats; k++) begin
            seq++;
            b.data = DS'({$urandom(), $urandom(), 8'(id), 24'(seq)});
            b.eop  = eop_last && (k == nbeats - 1);
            rq[id].push_back(b);
            e.id   = 3'(id);
            e.data = b.data;
            sb.push_back(e);
        end
    endtask

    // One clock: sample/compare at negedge, then advance the requester model after the edge.
    task automatic cycle();
        logic [N-1:0] ack_seen;
        exp_t e;
        @(negedge clk);
        ack_seen        = req_ack;
        last_gnt_active = gnt_active;
        last_gnt_id     = gnt_id;
        if (fifo_in_valid) begin
            writes++;
            check("write_while_stalled", DS'(fifo_in_stall), '0);
            if (sb.size() == 0) begin
                check("unexpected_write", DS'(1), '0);
            end else begin
                e = sb.pop_front();
                check("wr_id", DS'(gnt_id), DS'(e.id));
                check("wr_data", fifo_in, e.data);
                check("ack_onehot", DS'(req_ack), DS'(N'(1) << e.id));
            end
        end else begin
            check("ack_idle", DS'(req_ack), '0);
        end
        if (gnt_active && gnt_id < 3'(N)) check("fifo_in_hold", fifo_in, req_data[gnt_id*DS +: DS]);
        if (!gnt_active) check("fifo_in_zero", fifo_in, '0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (ack_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        drive_inputs();
    endtask

    function automatic bit busy();
        bit b = (sb.size() > 0);
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_until_empty(input int budget, output int cycles);
        cycles = 0;
        while (busy() && cycles < budget) begin
            cycle();
            cycles++;
        end
        if (busy()) check("drain_timeout", DS'(1), '0);
    endtask

    initial begin
        int c;
        int w0;
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0};

        // Reset held with every requester valid.
        for (int i = 0; i < N; i++) load_pkt(i, 1, 1'b1);
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_ack", DS'(req_ack), '0);
            check("rst_valid", DS'(fifo_in_valid), '0);
            check("rst_gnt_active", DS'(gnt_active), '0);
        end
        check("rst_err_len", DS'(err_len), '0);
        check("rst_err_ovf", DS'(err_ovf), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check("arb_bubble", DS'(last_gnt_active), '0);
        cycle();
        check("first_gnt_active", DS'(last_gnt_active), DS'(1));
        check("first_gnt_id", DS'(last_gnt_id), '0);
        run_until_empty(50, c);

        // Round-robin with 2-beat packets, all valid together.
        for (int i = 0; i < N; i++) load_pkt(i, 2, 1'b1);
        drive_inputs();
        w0 = writes;
        run_until_empty(100, c);
        check("rr_writes", DS'(writes - w0), DS'(8));
        check("rr_cycles", DS'(c), DS'(12));

        // Requesters 0 and 3 always valid with 1-beat packets.
`ifdef CR_KME_FIFO_ARB_PRIO0_EN
        for (int k = 0; k < 4; k++) load_pkt(0, 1, 1'b1);
        for (int k = 0; k < 4; k++) load_pkt(3, 1, 1'b1);
`else
        for (int k = 0; k < 4; k++) begin
            load_pkt(0, 1, 1'b1);
            load_pkt(3, 1, 1'b1);
        end
`endif
        drive_inputs();
        run_until_empty(100, c);
        check("prio_cycles", DS'(c), DS'(16));

        // Stall for 5 cycles in the middle of a 3-beat packet.
        load_pkt(1, 3, 1'b1);
        drive_inputs();
        cycle();
        cycle();
        check("stall_first_beat", DS'(writes - w0 - 16), DS'(1));
        w0 = writes;
        fifo_in_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_grant_held", DS'(last_gnt_active), DS'(1));
        end
        check("stall_no_writes", DS'(writes - w0), '0);
        fifo_in_stall = 1'b0;
        run_until_empty(20, c);
        check("stall_resume_cycles", DS'(c), DS'(2));

        // Watchdog: 6-beat packet against MAX_BEATS=4.
        load_pkt(2, 6, 1'b1);
        drive_inputs();
        w0 = writes;
        for (int k = 0; k < 4; k++) cycle();
        check("wd_pre_err", DS'(err_len), '0);
        cycle();
        check("wd_writes", DS'(writes - w0), DS'(4));
        check("wd_err_len", DS'(err_len), DS'(1));
        cycle();
        check("wd_released", DS'(last_gnt_active), '0);
        run_until_empty(20, c);
        check("wd_rest_cycles", DS'(c), DS'(2));
        check("wd_regrant_id", DS'(last_gnt_id), DS'(2));
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("wd_err_clr", DS'(err_len), '0);

        // Sticky overflow flag, including simultaneous set and clear.
        for (int v = 0; v < 8; v++) begin
            fifo_overflow = vecs[v].ovf;
            err_clr       = vecs[v].clr;
            cycle();
            check($sformatf("err_ovf_vec%0d", v), DS'(err_ovf), DS'(vecs[v].exp_ovf));
            check($sformatf("err_len_vec%0d", v), DS'(err_len), DS'(vecs[v].exp_len));
        end
        fifo_overflow = 1'b0;
        err_clr       = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
